// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default frame timing
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} uart_state_t;
  localparam int unsigned DEF_CLKS_PER_BIT = 105;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input, resets to 1
module sync_2ff (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Sync
);
  logic r_meta, r_sync;
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) {r_sync, r_meta} <= 2'b11;
    else {r_sync, r_meta} <= {r_meta, i_Async};
  assign o_Sync = r_sync;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with mid-bit sampling and framing-error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int          UART_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int          CONFIG_DATA_WIDTH = 32,
  parameter int unsigned CLKS_PER_BIT      = DEF_CLKS_PER_BIT
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_Rx_Serial,
  output logic                       o_Rx_DV,
  output logic [UART_DATA_WIDTH-1:0] o_Rx_Byte,
  output logic                       o_Rx_Active,
  output logic                       o_Rx_Frame_Err
);
  localparam int IW = $clog2(UART_DATA_WIDTH);
  localparam logic [CONFIG_DATA_WIDTH-1:0] LP_MID = CONFIG_DATA_WIDTH'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CONFIG_DATA_WIDTH-1:0] LP_LAST = CONFIG_DATA_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LP_LAST_IDX = IW'(UART_DATA_WIDTH - 1);

  uart_state_t r_state, w_next;
  logic [CONFIG_DATA_WIDTH-1:0] r_count;
  logic [IW-1:0] r_index;
  logic [UART_DATA_WIDTH-1:0] r_shift, r_byte;
  logic r_dv, r_err, r_active;
  logic w_rx_s, w_mid, w_last;

  sync_2ff u_sync (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .i_Async(i_Rx_Serial),
    .o_Sync (w_rx_s)
  );

  assign w_mid  = r_count == LP_MID;
  assign w_last = r_count == LP_LAST;

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:       w_next = w_rx_s ? IDLE : START;
      START:      w_next = !w_mid ? START : (w_rx_s ? IDLE : DATA);
      DATA:       w_next = (w_last && r_index == LP_LAST_IDX) ? STOP : DATA;
      STOP:       w_next = !w_last ? STOP : (w_rx_s ? IDLE : BREAK_WAIT);
      BREAK_WAIT: w_next = w_rx_s ? IDLE : BREAK_WAIT;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // The stop bit is judged at its midpoint, leaving half a bit to catch a back-to-back start
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      r_count  <= '0;
      r_index  <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
      r_active <= w_next != IDLE;
      r_count  <= (w_next != r_state || w_last || r_state inside {IDLE, BREAK_WAIT}) ? '0 : r_count + 1'b1;
      if (r_state == DATA && w_last) begin
        r_shift[r_index] <= w_rx_s;
        r_index          <= (r_index == LP_LAST_IDX) ? '0 : r_index + 1'b1;
      end
      if (r_state == STOP && w_last) begin
        if (w_rx_s) begin
          r_byte <= r_shift;
          r_dv   <= 1'b1;
        end else r_err <= 1'b1;
      end
    end

  assign o_Rx_DV        = r_dv;
  assign o_Rx_Byte      = r_byte;
  assign o_Rx_Active    = r_active;
  assign o_Rx_Frame_Err = r_err;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expectations
module tb_uart_rx;
  localparam int CPB = 105;
  localparam int FRAME_ACTIVE = 998;
  localparam int GLITCH_ACTIVE = 53;

  logic clk = 1'b0, rst_n = 1'b0, line = 1'b1;
  logic dv, err, act;
  logic [7:0] rx_byte;
  int vectors = 0, miscompares = 0;
  int dv_cnt = 0, err_cnt = 0, act_cnt = 0, both_cnt = 0, rd = 0;
  int d0, e0, a0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_rx dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_Serial   (line),
    .o_Rx_DV       (dv),
    .o_Rx_Byte     (rx_byte),
    .o_Rx_Active   (act),
    .o_Rx_Frame_Err(err)
  );

  always @(negedge clk)
    if (rst_n) begin
      if (dv) begin
        dv_cnt++;
        rx_q.push_back(rx_byte);
      end
      if (err) err_cnt++;
      if (act) act_cnt++;
      if (dv && err) both_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    logic [7:0] got;
    got = (rd < rx_q.size()) ? rx_q[rd] : 8'hxx;
    rd++;
    chk(tag, {24'd0, got}, {24'd0, b});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      line = f[i];
      idle(CPB);
    end
  endtask

  task automatic snap();
    d0 = dv_cnt;
    e0 = err_cnt;
    a0 = act_cnt;
  endtask

  initial begin
    idle(3);
    chk("rst_dv", dv, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_active", act, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    idle(5);
    // single byte
    snap();
    send(8'hA5, 1'b1, 10);
    idle(10);
    chk("a5_dv_count", dv_cnt - d0, 1);
    expect_byte("a5_byte", 8'hA5);
    chk("a5_err_count", err_cnt - e0, 0);
    chk("a5_active_cycles", act_cnt - a0, FRAME_ACTIVE);
    chk("a5_active_idle", act, 0);
    // back-to-back with no idle gap
    snap();
    send(8'h00, 1'b1, 10);
    send(8'hFF, 1'b1, 10);
    send(8'h3C, 1'b1, 10);
    idle(10);
    chk("b2b_dv_count", dv_cnt - d0, 3);
    expect_byte("b2b_byte0", 8'h00);
    expect_byte("b2b_byte1", 8'hFF);
    expect_byte("b2b_byte2", 8'h3C);
    chk("b2b_err_count", err_cnt - e0, 0);
    chk("b2b_active_cycles", act_cnt - a0, 3 * FRAME_ACTIVE);
    // glitch shorter than half a bit
    snap();
    line = 1'b0;
    idle(20);
    line = 1'b1;
    idle(100);
    chk("glitch_dv_count", dv_cnt - d0, 0);
    chk("glitch_err_count", err_cnt - e0, 0);
    chk("glitch_active_cycles", act_cnt - a0, GLITCH_ACTIVE);
    chk("glitch_active_idle", act, 0);
    send(8'h55, 1'b1, 10);
    idle(10);
    expect_byte("post_glitch_byte", 8'h55);
    // framing error
    snap();
    send(8'h81, 1'b0, 10);
    line = 1'b1;
    idle(100);
    chk("ferr_err_count", err_cnt - e0, 1);
    chk("ferr_dv_count", dv_cnt - d0, 0);
    chk("ferr_byte_held", rx_byte, 8'h55);
    send(8'h42, 1'b1, 10);
    idle(10);
    expect_byte("post_ferr_byte", 8'h42);
    // break: line held low for 30 bit periods
    snap();
    line = 1'b0;
    idle(30 * CPB);
    chk("brk_active_held", act, 1);
    chk("brk_err_count", err_cnt - e0, 1);
    chk("brk_dv_count", dv_cnt - d0, 0);
    line = 1'b1;
    idle(10);
    chk("brk_active_release", act, 0);
    send(8'h7E, 1'b1, 10);
    idle(10);
    expect_byte("post_brk_byte", 8'h7E);
    chk("post_brk_reg", rx_byte, 8'h7E);
    // reset during bit 4 of 0xC3
    send(8'hC3, 1'b1, 5);
    idle(50);
    rst_n = 1'b0;
    #1;
    chk("midrst_active", act, 0);
    chk("midrst_dv", dv, 0);
    chk("midrst_byte", rx_byte, 0);
    chk("midrst_err", err, 0);
    line = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    snap();
    send(8'h99, 1'b1, 10);
    idle(10);
    chk("post_rst_dv_count", dv_cnt - d0, 1);
    expect_byte("post_rst_byte", 8'h99);
    chk("dv_err_overlap", both_cnt, 0);
    chk("total_bytes", rx_q.size(), rd);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver, 8N1, LSB first; the receiving end of the team's UART link.
- Bit timing matches the paired transmitter: 105 clocks per bit by default.
- Synchronises the asynchronous line, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe.
- Flags framing errors; feeds the SHA host command path.

Parameters:
- UART_DATA_WIDTH, 8, data bits per frame. The FSM is written for 8; other values are unsupported.
- CONFIG_DATA_WIDTH, 32, width of the bit-period counter.
- CLKS_PER_BIT, 105, clocks per bit period. Legal range is 4 to 2^CONFIG_DATA_WIDTH-1.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- o_Rx_DV  out  1  one-cycle strobe: o_Rx_Byte holds a new, good byte.
- o_Rx_Byte  out  UART_DATA_WIDTH  last good byte; holds until the next good byte.
- o_Rx_Active  out  1  high while a frame is being received.
- o_Rx_Frame_Err  out  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Interface (already decided): one clock, i_Clock; reset i_Rst_n is asynchronous and active-low.
- Reset values:
  - o_Rx_DV=0, o_Rx_Byte=0, o_Rx_Active=0, o_Rx_Frame_Err=0.
  - FSM=IDLE, counter=0, bit index=0, shift register=0.
  - Both synchroniser flops reset to 1, so there is no false start after reset.
- Synchroniser: 2-flop chain. All FSM decisions use the second flop (rx_s). Input-to-FSM latency is 2 clocks.
- Bit counter: counts 0..CLKS_PER_BIT-1. MID = (CLKS_PER_BIT-1)/2, truncating; MID = 52 at the default.
- IDLE:
  - Counter=0, index=0, o_Rx_Active=0.
  - rx_s==0 → START, o_Rx_Active<=1.
- START:
  - Counter increments.
  - At count==MID: if rx_s==0, counter<=0 and go to DATA. If rx_s==1, this is a glitch or false start: go to IDLE with no strobe.
  - From this point every sample falls at mid-bit.
- DATA:
  - At count==CLKS_PER_BIT-1: shift rx_s into bit [index], counter<=0.
  - index<7 → index+1, stay in DATA. index==7 → index<=0, go to STOP.
- STOP: at count==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: o_Rx_Byte<=shift register, o_Rx_DV<=1 for one cycle, go to IDLE. This happens at mid-stop-bit, so a back-to-back start bit is caught.
  - rx_s==0: o_Rx_Frame_Err<=1 for one cycle; o_Rx_Byte unchanged, no DV; go to BREAK_WAIT.
- BREAK_WAIT:
  - o_Rx_Active stays 1.
  - Remain until rx_s==1, then go to IDLE.
  - Prevents a held-low line (break) from re-triggering frames.
- o_Rx_Active deasserts on the cycle the FSM enters IDLE.
- o_Rx_DV and o_Rx_Frame_Err are never high together; each is high for exactly one clock per frame.
- Latency: from the line falling edge to o_Rx_DV is 2 + (MID+1) + 9*CLKS_PER_BIT clocks, ±1 for edge phase. That is 1000 clocks at the default.
- Line activity mid-frame is ignored except at the sample points. No oversampling or majority vote.
- Reset asserted mid-frame: all state clears at once, with no strobe. After release the FSM waits for a fresh falling edge; a partial frame is lost.
- Illegal FSM encoding → IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK_WAIT), 3 bits;
  - the default CLKS_PER_BIT (105);
  - the default UART_DATA_WIDTH.
- One natural sub-module: sync_2ff, a reset-to-1 two-flop synchroniser. It is reusable for other asynchronous inputs.

Test Plan:
- Single byte: drive 0xA5 framed 8N1 at 105 clk/bit → exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Rx_Frame_Err never high, o_Rx_Active high for the frame duration.
- Back-to-back, zero idle gap: 0x00, 0xFF, 0x3C → three DV pulses in order with bytes 0x00, 0xFF, 0x3C; no frame lost.
- Glitch: pulse line low for 20 clocks, then high → no DV, no error; o_Rx_Active returns to 0 by count MID; a following 0x55 frame is received correctly.
- Framing error: send 0x81 with stop bit = 0, then return high → one o_Rx_Frame_Err pulse, no DV, o_Rx_Byte keeps the prior value; next frame 0x42 is received.
- Break: hold line low for 30 bit periods → exactly one Frame_Err with no DV; FSM stays in BREAK_WAIT until high, then receives 0x7E normally.
- Reset mid-frame: assert i_Rst_n=0 during bit 4 of 0xC3 → all outputs 0 at once; after release, a full 0x99 frame yields DV with 0x99.
